// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall request.
// Optional FORWARDING_EN: EX/MEM and MEM/WB bypass; otherwise RAW hazards stall until writeback.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [15:0] id_imm16,
    input  logic        id_ext_op,
    input  logic        id_alusrc,
    input  logic [2:0]  id_alu_op,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memtoreg,
    input  logic        id_memwrite,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_waddr,
    output logic        ex_regwrite,
    output logic        ex_memtoreg,
    output logic        ex_memwrite,
    output logic        load_use_stall
);
    localparam logic [2:0] ALU_ADD = 3'b000;

    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [31:0] r_rs_val;
    logic [31:0] r_rt_val;
    logic [31:0] r_imm32;
    logic        r_alusrc;
    logic [2:0]  r_alu_op;
    logic [4:0]  r_waddr;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic        r_memwrite;

    logic [31:0] w_imm32;
    logic [4:0]  w_waddr;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic        w_use_rt;

    assign w_imm32 = id_ext_op ? {{16{id_imm16[15]}}, id_imm16} : {16'h0000, id_imm16};
    assign w_waddr = id_regwrite ? (id_regdst ? id_rd : id_rt) : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rs_val   <= 32'd0;
            r_rt_val   <= 32'd0;
            r_imm32    <= 32'd0;
            r_alusrc   <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_waddr    <= 5'd0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_rs       <= 5'd0;
                r_rt       <= 5'd0;
                r_rs_val   <= 32'd0;
                r_rt_val   <= 32'd0;
                r_imm32    <= 32'd0;
                r_alusrc   <= 1'b0;
                r_alu_op   <= ALU_ADD;
                r_waddr    <= 5'd0;
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                r_rs       <= id_rs;
                r_rt       <= id_rt;
                r_rs_val   <= id_rs_val;
                r_rt_val   <= id_rt_val;
                r_imm32    <= w_imm32;
                r_alusrc   <= id_alusrc;
                r_alu_op   <= id_alu_op;
                r_waddr    <= w_waddr;
                r_regwrite <= id_regwrite;
                r_memtoreg <= id_memtoreg;
                r_memwrite <= id_memwrite;
            end
        end
    end

    // rt is a real source unless the B operand is the immediate of a non-store
    assign w_use_rt = ~id_alusrc | id_memwrite;

`ifdef FORWARDING_EN
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] val);
        if (mem_regwrite && mem_waddr != 5'd0 && mem_waddr == src)
            return mem_wdata;
        else if (wb_regwrite && wb_waddr != 5'd0 && wb_waddr == src)
            return wb_wdata;
        else
            return val;
    endfunction

    assign w_fwd_rs = fwd(r_rs, r_rs_val);
    assign w_fwd_rt = fwd(r_rt, r_rt_val);

    always_comb begin
        load_use_stall = 1'b0;
        if (r_memtoreg && r_waddr != 5'd0 &&
            (r_waddr == id_rs || (r_waddr == id_rt && w_use_rt)))
            load_use_stall = 1'b1;
    end
`else
    logic w_unused;
    assign w_unused = ^{r_rs, r_rt, mem_wdata, wb_regwrite, wb_waddr, wb_wdata};

    assign w_fwd_rs = r_rs_val;
    assign w_fwd_rt = r_rt_val;

    // Without bypass every pending writer in EX or MEM blocks a dependent ID instruction
    always_comb begin
        load_use_stall = 1'b0;
        if (r_regwrite && r_waddr != 5'd0 &&
            (r_waddr == id_rs || (r_waddr == id_rt && w_use_rt)))
            load_use_stall = 1'b1;
        if (mem_regwrite && mem_waddr != 5'd0 &&
            (mem_waddr == id_rs || (mem_waddr == id_rt && w_use_rt)))
            load_use_stall = 1'b1;
    end
`endif

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_alusrc ? r_imm32 : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign ex_waddr      = r_waddr;
    assign ex_regwrite   = r_regwrite;
    assign ex_memtoreg   = r_memtoreg;
    assign ex_memwrite   = r_memwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations track the FORWARDING_EN build option.
module tb_id_ex_stage;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val;
    logic [15:0] id_imm16;
    logic        id_ext_op, id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite;
    logic [2:0]  id_alu_op;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_waddr, wb_waddr;
    logic [31:0] mem_wdata, wb_wdata;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_op;
    logic [4:0]  ex_waddr;
    logic        ex_regwrite, ex_memtoreg, ex_memwrite, load_use_stall;

    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_ext_op(id_ext_op), .id_alusrc(id_alusrc), .id_alu_op(id_alu_op),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite),
        .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_waddr(ex_waddr), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // nonzero ID inputs while held in reset
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd4;
        id_rs_val = 32'd5; id_rt_val = 32'd7; id_imm16 = 16'h1234;
        id_ext_op = 1'b1; id_alusrc = 1'b0; id_alu_op = ALU_SUB;
        id_regdst = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1; id_memwrite = 1'b1;
        mem_regwrite = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'hDEAD;
        wb_regwrite = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'hBEEF;
        tick(); tick();
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
        chk("rst_waddr", {27'd0, ex_waddr}, 32'd0);
        chk("rst_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'd0);
        chk("rst_lus", {31'd0, load_use_stall}, 32'd0);

        // first capture after reset
        reset = 1'b0; id_memtoreg = 1'b0; id_memwrite = 1'b0;
        tick();
        chk("cap_alu_a", alu_a, 32'd5);
        chk("cap_alu_b", alu_b, 32'd7);
        chk("cap_store", ex_store_data, 32'd7);
        chk("cap_alu_op", {29'd0, alu_op}, {29'd0, ALU_SUB});
        chk("cap_waddr_rd", {27'd0, ex_waddr}, 32'd4);

        // immediate extension and destination select
        id_imm16 = 16'hFFFC; id_alusrc = 1'b1; id_ext_op = 1'b1; id_regdst = 1'b0;
        tick();
        chk("imm_sext", alu_b, 32'hFFFF_FFFC);
        chk("waddr_rt", {27'd0, ex_waddr}, 32'd2);
        id_ext_op = 1'b0; id_regwrite = 1'b0;
        tick();
        chk("imm_zext", alu_b, 32'h0000_FFFC);
        chk("waddr_nowr", {27'd0, ex_waddr}, 32'd0);

        // forwarding priority on rs
        id_rs = 5'd3; id_rs_val = 32'h33; id_alusrc = 1'b0; id_regwrite = 1'b0;
        tick();
        mem_regwrite = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h11;
        wb_regwrite = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h22;
        #1;
        chk("fwd_mem_wins", alu_a, FWD ? 32'h11 : 32'h33);
        mem_regwrite = 1'b0;
        #1;
        chk("fwd_wb", alu_a, FWD ? 32'h22 : 32'h33);
        id_rs = 5'd0; id_rs_val = 32'h44;
        mem_regwrite = 1'b1; mem_waddr = 5'd0; wb_waddr = 5'd0;
        tick();
        chk("fwd_r0", alu_a, 32'h44);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        // load-use: lw writing $8 sits in EX
        id_rt = 5'd8; id_regdst = 1'b0; id_regwrite = 1'b1; id_memtoreg = 1'b1;
        id_alusrc = 1'b1;
        tick();
        id_rs = 5'd8; id_rt = 5'd1; id_regwrite = 1'b0; id_memtoreg = 1'b0;
        #1;
        chk("lu_rs", {31'd0, load_use_stall}, 32'd1);
        id_rs = 5'd9; id_rt = 5'd8; id_alusrc = 1'b1; id_memwrite = 1'b0;
        #1;
        chk("lu_rt_imm", {31'd0, load_use_stall}, 32'd0);
        id_memwrite = 1'b1;
        #1;
        chk("lu_rt_store", {31'd0, load_use_stall}, 32'd1);
        // ALU (non-load) writer of $8 in EX
        id_rt = 5'd8; id_regwrite = 1'b1; id_memtoreg = 1'b0; id_memwrite = 1'b0;
        tick();
        id_rs = 5'd8; id_rt = 5'd1; id_regwrite = 1'b0;
        #1;
        chk("raw_alu", {31'd0, load_use_stall}, FWD ? 32'd0 : 32'd1);

        // stall holds, stall beats flush, flush alone bubbles
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd5; id_rs_val = 32'hA; id_rt_val = 32'hB;
        id_alusrc = 1'b0; id_regdst = 1'b1; id_regwrite = 1'b1; id_memwrite = 1'b1;
        id_alu_op = ALU_SUB;
        tick();
        id_rs_val = 32'h99; id_rt_val = 32'h98; id_rd = 5'd6; id_alu_op = 3'b011;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_alu_a", alu_a, 32'hA);
            chk("stall_waddr", {27'd0, ex_waddr}, 32'd5);
        end
        flush = 1'b1;
        tick();
        chk("stall_flush_b", alu_b, 32'hB);
        chk("stall_flush_wr", {31'd0, ex_regwrite}, 32'd1);
        stall = 1'b0;
        tick();
        chk("flush_ctrl", {29'd0, ex_regwrite, ex_memtoreg, ex_memwrite}, 32'd0);
        chk("flush_waddr", {27'd0, ex_waddr}, 32'd0);
        chk("flush_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
        flush = 1'b0;

        // async reset between edges
        id_rs_val = 32'h55; id_alu_op = ALU_SUB;
        tick();
        chk("pre_arst_a", alu_a, 32'h55);
        #2 reset = 1'b1;
        #1;
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_wr", {31'd0, ex_regwrite}, 32'd0);
        chk("arst_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
        reset = 1'b0;
        tick();
        chk("post_arst_a", alu_a, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-selection stage sitting directly upstream of the EX-stage ALU. Captures decoded instruction fields each cycle and applies stall (hold) and flush (bubble) control. Drives the ALU's A, B and ALUOp inputs with values resolved through EX/MEM and MEM/WB forwarding. Also raises the load-use stall request consumed by the hazard unit.

## Interface
- No parameters; data width fixed at 32, register address width at 5.
- clk  in  1  pipeline clock, rising-edge active
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold current ID/EX contents (priority below reset, above flush)
- flush  in  1  load a bubble (all control zero) on next edge
- id_rs, id_rt, id_rd  in  5 each  decoded register addresses
- id_rs_val, id_rt_val  in  32 each  register-file read data
- id_imm16  in  16  instruction immediate
- id_ext_op  in  1  1 = sign-extend imm, 0 = zero-extend
- id_alusrc  in  1  1 = B from extended immediate, 0 = B from rt
- id_alu_op  in  3  ALU operation in the define.v ALUOp encoding (ALU_ADD/ALU_SUB/ALU_OR/ALU_COM)
- id_regdst  in  1  1 = write rd, 0 = write rt
- id_regwrite, id_memtoreg, id_memwrite  in  1 each  control bits
- mem_regwrite  in  1, mem_waddr  in  5, mem_wdata  in  32  EX/MEM forwarding source
- wb_regwrite  in  1, wb_waddr  in  5, wb_wdata  in  32  MEM/WB forwarding source
- alu_a, alu_b  out  32 each  resolved ALU operands
- alu_op  out  3  registered ALUOp
- ex_store_data  out  32  forwarded rt value for stores
- ex_waddr  out  5  destination register (0 when no write)
- ex_regwrite, ex_memtoreg, ex_memwrite  out  1 each  registered control
- load_use_stall  out  1  combinational stall request to hazard unit

## Operation
- Register update on rising clk: reset > stall (hold) > flush (bubble) > capture.
- Bubble: all control bits 0, ex_waddr 0, alu_op ALU_ADD, data fields 0.
- Capture: immediate extended at capture (ext_op), stored as 32-bit imm; ex_waddr = regdst ? rd : rt; ex_waddr forced 0 if regwrite 0.
- Forwarding per source (rs, rt), combinational from registered address/value: if mem_regwrite and mem_waddr != 0 and mem_waddr == src -> mem_wdata; else if wb_regwrite and wb_waddr != 0 and wb_waddr == src -> wb_wdata; else registered value. EX/MEM wins over MEM/WB on simultaneous match.
- Register $0 never forwarded; address 0 always yields registered value.
- alu_a = fwd_rs; alu_b = alusrc ? imm32 : fwd_rt; ex_store_data = fwd_rt always.
- load_use_stall = ex_memtoreg & (ex_waddr != 0) & (ex_waddr == id_rs | (ex_waddr == id_rt & ~id_alusrc_or_store)); rt compared when id_alusrc = 0 or id_memwrite = 1.
- Hazard unit responds with stall of IF/ID and flush of this stage; flush on same cycle as stall is ignored (stall wins).

## Timing
- Reset values: every registered output 0, alu_op = ALU_ADD, load_use_stall 0 (ex_memtoreg 0).
- Latency: ID fields appear at outputs one cycle after capture edge; forwarding adds zero cycles.
- Stall held for N cycles keeps outputs constant N cycles; forwarded operands may still change as MEM/WB sources change.
- Reset asserted mid-stall or mid-flush clears immediately, independent of clk.

## Configuration
- FORWARDING_EN defined: forwarding muxes as above; load_use_stall covers only load-use.
- FORWARDING_EN undefined: operands come straight from registered values; load_use_stall extends to any ID source matching a nonzero ex_waddr with ex_regwrite, or mem_waddr with mem_regwrite (RAW stall until writeback).

## Test plan
- Reset: assert reset with nonzero inputs -> all outputs 0, alu_op ALU_ADD; deassert, capture id_rs_val=5, id_rt_val=7 -> alu_a=5, alu_b=7 next cycle.
- Immediate: id_imm16=16'hFFFC, alusrc=1, ext_op=1 -> alu_b=32'hFFFFFFFC; ext_op=0 -> 32'h0000FFFC.
- Forward priority: rs=3, mem_waddr=3 data 0x11, wb_waddr=3 data 0x22, both regwrite -> alu_a=0x11; drop mem_regwrite -> 0x22; rs=0 with matches -> registered value.
- Load-use: EX holds lw to $8, ID rs=8 -> load_use_stall=1; ID rs=9, rt=8 with alusrc=1, memwrite=0 -> 0.
- Stall/flush: stall=1 for 3 cycles -> outputs unchanged; stall=1 and flush=1 -> hold; flush alone -> ex_regwrite=0, ex_memwrite=0, ex_waddr=0.
- Async reset mid-operation: pulse reset between edges -> outputs clear before next clk.
